// File: rtl/ahb_apb_pkg.sv
// Shared definitions for the AHB-to-APB bridge.
//   - HTRANS / HRESP encodings
//   - bridge FSM state enum
//   - helper that recognises a transfer-carrying HTRANS code
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WLATCH,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // IDLE and BUSY carry no transfer; only NONSEQ and SEQ start an APB access.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_apb_strb_gen.sv
// APB write-strobe generator.
//   hsize    : AHB transfer size (log2 of byte count)
//   addr_lsb : low address bits selecting the byte lane
//   strb     : one bit per byte lane of the data bus
// A lane is enabled when it lies in the same size-aligned block as the
// address, which for naturally aligned AHB transfers is exactly the set of
// addressed bytes.
module ahb_apb_strb_gen #(
  parameter int DATA_W = 32
) (
  input  logic [2:0]                  hsize,
  input  logic [$clog2(DATA_W/8)-1:0] addr_lsb,
  output logic [DATA_W/8-1:0]         strb
);

  localparam int NB = DATA_W / 8;

  always_comb begin
    strb = '0;
    for (int b = 0; b < NB; b++) begin
      strb[b] = ((b >> hsize) == (int'(addr_lsb) >> hsize));
    end
  end

endmodule

// File: rtl/ahb_apb_bridge_nslv.sv
// AHB-Lite to APB bridge with NUM_SLV APB slaves.
//   CLK / HRESET          : clock, asynchronous active-high reset
//   HADDR..HREADY_IN      : AHB slave-side request inputs (HBURST ignored)
//   HREADY_OUT/HRESP      : AHB response, decoded from the state register only
//   HRDATA                : registered read data
//   PADDR..PENABLE        : registered APB master outputs, PSEL one-hot
//   PRDATA/PREADY/PSLVERR : per-slave APB returns, slave i in slice i
module ahb_apb_bridge_nslv
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 0
) (
  input  logic                      CLK,
  input  logic                      HRESET,
  input  logic [ADDR_W-1:0]         HADDR,
  input  logic                      HWRITE,
  input  logic [1:0]                HTRANS,
  input  logic [2:0]                HSIZE,
  input  logic [2:0]                HBURST,
  input  logic [DATA_W-1:0]         HWDATA,
  input  logic                      HREADY_IN,
  output logic                      HREADY_OUT,
  output logic [DATA_W-1:0]         HRDATA,
  output logic [1:0]                HRESP,
  output logic [ADDR_W-1:0]         PADDR,
  output logic                      PWRITE,
  output logic [DATA_W-1:0]         PWDATA,
  output logic [DATA_W/8-1:0]       PSTRB,
  output logic [NUM_SLV-1:0]        PSEL,
  output logic                      PENABLE,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR
);

  localparam int         NB       = DATA_W / 8;
  localparam int         LSB_W    = $clog2(NB);
  localparam int         SEL_W    = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int         CNT_W    = $clog2(TIMEOUT + 2);
  localparam logic [2:0] MAX_SIZE = 3'(LSB_W);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [NB-1:0]       pstrb_q, pstrb_d;
  logic [NUM_SLV-1:0]  psel_q, psel_d;
  logic                penable_q, penable_d;
  logic [DATA_W-1:0]   hrdata_q, hrdata_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;

  logic                hready_out;
  logic [1:0]          hresp;
  logic                accept, req_bad, timeout_hit;
  logic                pready_sel, pslverr_sel;
  logic [DATA_W-1:0]   prdata_sel;
  logic [NB-1:0]       strb_new;
  logic [SEL_W-1:0]    req_idx, cur_idx;
  logic                unused_hburst;

  assign unused_hburst = ^HBURST;

  assign accept  = htrans_active(HTRANS) & HREADY_IN & hready_out;
  assign req_idx = HADDR[SEL_LSB +: SEL_W];
  assign req_bad = (32'(req_idx) >= NUM_SLV) || (HSIZE > MAX_SIZE);

  // Last ACCESS cycle before the counter would reach TIMEOUT.
  assign timeout_hit = (TIMEOUT > 0) &&
                       (wait_cnt_q == CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0));

  ahb_apb_strb_gen #(.DATA_W(DATA_W)) u_strb_gen (
    .hsize    (HSIZE),
    .addr_lsb (HADDR[LSB_W-1:0]),
    .strb     (strb_new)
  );

  // The registered one-hot PSEL doubles as the return-path mux select.
  always_comb begin
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    prdata_sel  = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (psel_q[i]) begin
        pready_sel  |= PREADY[i];
        pslverr_sel |= PSLVERR[i];
        prdata_sel  |= PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  // State register.
  // NOTE: flops use non-blocking assignments so every register samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge CLK or posedge HRESET) begin
    if (HRESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (accept)      state_d = req_bad ? ST_ERR1 : (HWRITE ? ST_WLATCH : ST_SETUP);
        else             state_d = ST_IDLE;
      end
      ST_WLATCH:         state_d = ST_SETUP;
      ST_SETUP:          state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (pready_sel)  state_d = pslverr_sel ? ST_ERR1 : ST_IDLE;
        else if (timeout_hit) state_d = ST_ERR1;
      end
      ST_ERR1:           state_d = ST_ERR2;
      default:           state_d = ST_IDLE;
    endcase
  end

  // AHB response decodes from the state register alone.
  always_comb begin
    hready_out = !(state_q inside {ST_WLATCH, ST_SETUP, ST_ACCESS, ST_ERR1});
    hresp      = (state_q inside {ST_ERR1, ST_ERR2}) ? HRESP_ERROR : HRESP_OKAY;
  end

  // Datapath next values.
  always_comb begin
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pstrb_d  = pstrb_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    if (accept) begin
      paddr_d  = HADDR;
      pwrite_d = HWRITE;
      pstrb_d  = HWRITE ? strb_new : '0;
    end
    // Write data arrives in the AHB data phase, i.e. the WLATCH cycle.
    if (state_q == ST_WLATCH) pwdata_d = HWDATA;
    if (state_q == ST_ACCESS && pready_sel && !pslverr_sel) hrdata_d = prdata_sel;

    // PSEL follows the next state so it is already valid in the SETUP cycle.
    cur_idx = paddr_d[SEL_LSB +: SEL_W];
    psel_d  = '0;
    if (state_d inside {ST_SETUP, ST_ACCESS}) begin
      for (int i = 0; i < NUM_SLV; i++) psel_d[i] = (cur_idx == SEL_W'(i));
    end
    penable_d = (state_d == ST_ACCESS);

    // Cleared outside ACCESS, so it is zero on every ACCESS entry.
    wait_cnt_d = (state_q == ST_ACCESS && TIMEOUT > 0) ? wait_cnt_q + CNT_W'(1) : '0;
  end

  always_ff @(posedge CLK or posedge HRESET) begin
    if (HRESET) begin
      paddr_q    <= '0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
      pstrb_q    <= '0;
      psel_q     <= '0;
      penable_q  <= 1'b0;
      hrdata_q   <= '0;
      wait_cnt_q <= '0;
    end else begin
      paddr_q    <= paddr_d;
      pwrite_q   <= pwrite_d;
      pwdata_q   <= pwdata_d;
      pstrb_q    <= pstrb_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      hrdata_q   <= hrdata_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign HREADY_OUT = hready_out;
  assign HRESP      = hresp;
  assign HRDATA     = hrdata_q;
  assign PADDR      = paddr_q;
  assign PWRITE     = pwrite_q;
  assign PWDATA     = pwdata_q;
  assign PSTRB      = pstrb_q;
  assign PSEL       = psel_q;
  assign PENABLE    = penable_q;

endmodule

// File: tb/tb_ahb_apb_bridge_nslv.sv
// Self-checking bench for ahb_apb_bridge_nslv (NUM_SLV=4, DATA_W=32, TIMEOUT=8).
// The bench plays both the AHB master and the APB slaves. For every transfer
// it derives the expected cycle-by-cycle bus picture from the protocol rules
// and compares it with the DUT outputs at the falling clock edge.
module tb_ahb_apb_bridge_nslv;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int NUM_SLV = 4;
  localparam int SEL_LSB = 12;
  localparam int TIMEOUT = 8;

  logic                      CLK = 1'b0;
  logic                      HRESET = 1'b0;
  logic [ADDR_W-1:0]         HADDR = '0;
  logic                      HWRITE = 1'b0;
  logic [1:0]                HTRANS = 2'b00;
  logic [2:0]                HSIZE = 3'd0;
  logic [2:0]                HBURST = 3'd0;
  logic [DATA_W-1:0]         HWDATA = '0;
  logic                      HREADY_IN = 1'b1;
  logic                      HREADY_OUT;
  logic [DATA_W-1:0]         HRDATA;
  logic [1:0]                HRESP;
  logic [ADDR_W-1:0]         PADDR;
  logic                      PWRITE;
  logic [DATA_W-1:0]         PWDATA;
  logic [DATA_W/8-1:0]       PSTRB;
  logic [NUM_SLV-1:0]        PSEL;
  logic                      PENABLE;
  logic [NUM_SLV*DATA_W-1:0] PRDATA = '0;
  logic [NUM_SLV-1:0]        PREADY = '0;
  logic [NUM_SLV-1:0]        PSLVERR = '0;

  ahb_apb_bridge_nslv #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV),
    .SEL_LSB(SEL_LSB), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .HRESET(HRESET), .HADDR(HADDR), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HREADY_IN(HREADY_IN), .HREADY_OUT(HREADY_OUT), .HRDATA(HRDATA),
    .HRESP(HRESP), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DATA_W-1:0] exp_hrdata = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected bus picture for one cycle, plus what the selected slave drives.
  typedef struct {
    logic       hready;
    logic [1:0] hresp;
    logic [3:0] psel;
    logic       penable;
    logic       pready;
    logic       perr;
  } cyc_t;

  function automatic cyc_t mk(input logic h, input logic [1:0] r, input logic [3:0] s,
                              input logic en, input logic rdy, input logic err);
    cyc_t c;
    c.hready = h; c.hresp = r; c.psel = s; c.penable = en; c.pready = rdy; c.perr = err;
    return c;
  endfunction

  // Bytes lsb .. lsb + 2**size - 1 are written.
  function automatic logic [3:0] model_strb(input logic [2:0] size, input logic [1:0] lsb);
    logic [3:0] s;
    int nbytes;
    s = '0;
    nbytes = 1 << size;
    for (int b = 0; b < 4; b++) if (b >= int'(lsb) && b < int'(lsb) + nbytes) s[b] = 1'b1;
    return s;
  endfunction

  // Unselected slaves drive noise; the selected one follows the plan.
  task automatic drive_slaves(input int slv, input logic is_acc, input logic rdy,
                              input logic err, input logic [31:0] rdata);
    PREADY  = 4'($urandom);
    PSLVERR = 4'($urandom);
    for (int i = 0; i < NUM_SLV; i++) PRDATA[i*DATA_W +: DATA_W] = $urandom;
    if (is_acc) begin
      PREADY[slv]  = rdy;
      PSLVERR[slv] = err;
    end
    PRDATA[slv*DATA_W +: DATA_W] = rdata;
  endtask

  // One AHB transfer, started from a cycle in which HREADY_OUT is expected high.
  // Returns at the falling edge of the completion cycle.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [1:0] trans, input logic [31:0] wdata, input int waits,
                      input logic slverr, input logic [31:0] rdata);
    cyc_t q[$];
    cyc_t e;
    logic bad, ok, timed_out;
    int slv, n_acc;
    logic [3:0] oh, strb;
    bad       = (size > 3'd2);
    slv       = int'(addr[SEL_LSB +: 2]);
    oh        = 4'b0001 << slv;
    strb      = wr ? model_strb(size, addr[1:0]) : 4'b0000;
    timed_out = (waits >= TIMEOUT);
    n_acc     = timed_out ? TIMEOUT : waits + 1;
    ok        = 1'b0;
    if (bad) begin
      q.push_back(mk(1'b0, 2'b01, 4'b0, 1'b0, 1'b0, 1'b0));
      q.push_back(mk(1'b1, 2'b01, 4'b0, 1'b0, 1'b0, 1'b0));
    end else begin
      if (wr) q.push_back(mk(1'b0, 2'b00, 4'b0, 1'b0, 1'b0, 1'b0));
      q.push_back(mk(1'b0, 2'b00, oh, 1'b0, 1'b0, 1'b0));
      for (int k = 0; k < n_acc; k++)
        q.push_back(mk(1'b0, 2'b00, oh, 1'b1, (k == waits), slverr && (k == waits)));
      ok = !timed_out && !slverr;
      if (ok) q.push_back(mk(1'b1, 2'b00, 4'b0, 1'b0, 1'b0, 1'b0));
      else begin
        q.push_back(mk(1'b0, 2'b01, 4'b0, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(1'b1, 2'b01, 4'b0, 1'b0, 1'b0, 1'b0));
      end
    end

    HREADY_IN = 1'b1;
    HADDR = addr; HWRITE = wr; HSIZE = size; HTRANS = trans;
    @(posedge CLK); #1;
    HTRANS = 2'b00; HADDR = $urandom; HWRITE = 1'($urandom); HSIZE = 3'($urandom);
    HWDATA = wdata;
    for (int c = 0; c < q.size(); c++) begin
      e = q[c];
      if (c > 0) begin
        @(posedge CLK); #1;
        HWDATA = $urandom;
      end
      drive_slaves(slv, e.penable, e.pready, e.perr, rdata);
      @(negedge CLK);
      check($sformatf("phase a=%0h c=%0d", addr, c), {HREADY_OUT, HRESP, PSEL, PENABLE},
            {e.hready, e.hresp, e.psel, e.penable});
      if (e.psel != 4'b0 && !e.penable) begin
        check("setup_paddr", PADDR, addr);
        check("setup_pwrite", PWRITE, wr);
        check("setup_pstrb", PSTRB, strb);
        if (wr) check("setup_pwdata", PWDATA, wdata);
      end
    end
    if (ok) exp_hrdata = rdata;
    check("hrdata", HRDATA, exp_hrdata);
  endtask

  // Cycles with no accepted transfer: IDLE, BUSY, or NONSEQ with HREADY_IN low.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 2))
        0:       begin HTRANS = 2'b00; HREADY_IN = 1'b1; end
        1:       begin HTRANS = 2'b01; HREADY_IN = 1'b1; end
        default: begin HTRANS = 2'b10; HREADY_IN = 1'b0; end
      endcase
      HADDR = $urandom; HWRITE = 1'($urandom);
      @(posedge CLK); #1;
      drive_slaves(0, 1'b0, 1'b0, 1'b0, $urandom);
      @(negedge CLK);
      check("idle", {HREADY_OUT, HRESP, PSEL, PENABLE}, 8'b1_00_0000_0);
    end
    HTRANS = 2'b00; HREADY_IN = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out"}, {HREADY_OUT, HRESP, PSEL, PENABLE, PWRITE}, 9'b1_00_0000_0_0);
    check({tag, "_paddr"}, PADDR, 32'h0);
    check({tag, "_pwdata"}, PWDATA, 32'h0);
    check({tag, "_pstrb"}, PSTRB, 4'h0);
    check({tag, "_hrdata"}, HRDATA, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        wr, se;
    logic [2:0]  sz;
    logic [1:0]  mask;
    logic [31:0] a;
    int          wt;

    #1 HRESET = 1'b1;
    #1 check_reset_state("rst_async");
    repeat (2) @(negedge CLK);
    check_reset_state("rst_held");
    HRESET = 1'b0;

    // Read from slave 1, no wait states; data returned in the third cycle.
    xfer(1'b0, 32'h0000_1004, 3'd2, 2'b10, 32'h0, 0, 1'b0, 32'hCAFE_F00D);
    // Byte write to the top lane of slave 2.
    xfer(1'b1, 32'h0000_2003, 3'd0, 2'b10, 32'hAA00_0000, 0, 1'b0, $urandom);
    // Five wait states then a slave error.
    xfer(1'b0, 32'h0000_3000, 3'd2, 2'b10, 32'h0, 5, 1'b1, $urandom);
    // INCR4 write burst to slave 0, each beat accepted in the previous completion.
    HBURST = 3'b011;
    for (int i = 0; i < 4; i++)
      xfer(1'b1, 32'(i * 4), 3'd2, (i == 0) ? 2'b10 : 2'b11, $urandom, 0, 1'b0, $urandom);
    HBURST = 3'b000;
    // Slave never ready: timeout after TIMEOUT access cycles.
    xfer(1'b0, 32'h0000_1008, 3'd2, 2'b10, 32'h0, 50, 1'b0, $urandom);
    // Oversized transfer, then a read accepted in the ERR2 cycle.
    xfer(1'b1, 32'h0000_2000, 3'd3, 2'b10, $urandom, 0, 1'b0, $urandom);
    xfer(1'b0, 32'h0000_3008, 3'd1, 2'b10, 32'h0, 1, 1'b0, 32'h1234_5678);
    xfer(1'b1, 32'h0000_0006, 3'd1, 2'b10, 32'h5A5A_0000, 2, 1'b0, $urandom);
    idle_cycles(3);

    // Reset during ACCESS: outputs return to reset values without a clock edge.
    HADDR = 32'h0000_3010; HWRITE = 1'b0; HSIZE = 3'd2; HTRANS = 2'b10;
    @(posedge CLK); #1;
    HTRANS = 2'b00;
    @(posedge CLK); #1;
    drive_slaves(3, 1'b1, 1'b0, 1'b0, $urandom);
    @(negedge CLK);
    check("pre_rst_access", {PSEL, PENABLE}, 5'b1000_1);
    #2 HRESET = 1'b1;
    #1 check_reset_state("rst_mid");
    exp_hrdata = '0;
    @(negedge CLK);
    HRESET = 1'b0;
    idle_cycles(1);

    // Randomized traffic with occasional gaps.
    for (int n = 0; n < 60; n++) begin
      wr   = 1'($urandom);
      sz   = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      a    = $urandom;
      a[SEL_LSB +: 2] = 2'($urandom_range(0, NUM_SLV - 1));
      mask = ~2'((1 << sz) - 1);
      a[1:0] = a[1:0] & mask;
      wt   = ($urandom_range(0, 9) == 9) ? $urandom_range(8, 12) : $urandom_range(0, 3);
      se   = ($urandom_range(0, 7) == 0);
      xfer(wr, a, sz, 2'b10, $urandom, wt, se, $urandom);
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
